umi_ram_sched: RTL and testbench
================================

// Module: umi_ram_sched
// PURPOSE
// - N-port round-robin scheduler sharing one single-ported UMI RAM device port among N host request channels.
// - Sits between the N udev_req/udev_resp host ports and the single mem_req/mem_resp port of the RAM datapath.
// - Registers the winning request toward memory.
// - Returns in-order memory responses to the originating port through a tag FIFO.
// PARAMETERS
// - N           5    number of host ports (1..16)
// - CW          32   UMI command width
// - AW          64   UMI address width
// - DW          256  UMI data width
// - OUTSTANDING 4    max response-expecting requests in flight (power of 2, >=2)
// PORTS
// - clk               in   1        clock
// - reset             in   1        synchronous active-high reset
// - udev_req_valid    in   N        per-port request valid
// - udev_req_cmd      in   N*CW     per-port command, port i at [i*CW+:CW]
// - udev_req_dstaddr  in   N*AW     per-port destination address
// - udev_req_srcaddr  in   N*AW     per-port source (return) address
// - udev_req_data     in   N*DW     per-port write data
// - udev_req_ready    out  N        per-port accept, one-hot or zero
// - mem_req_valid     out  1        request to RAM valid
// - mem_req_cmd/dstaddr/srcaddr/data  out  CW/AW/AW/DW  registered winning request
// - mem_req_ready     in   1        RAM accepts request
// - mem_resp_valid    in   1        RAM response valid (in request order)
// - mem_resp_cmd/dstaddr/srcaddr/data in CW/AW/AW/DW  RAM response
// - mem_resp_ready    out  1        response consumed
// - udev_resp_valid   out  N        per-port response valid, one-hot or zero
// - udev_resp_cmd/dstaddr/srcaddr/data out N*CW/N*AW/N*AW/N*DW  mem_resp fields broadcast to all ports
// - udev_resp_ready   in   N        per-port response ready
// - outstanding       out  $clog2(OUTSTANDING)+1  tag FIFO occupancy
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset values: mem_req_valid=0, udev_req_ready=0, udev_resp_valid=0, mem_resp_ready=0, outstanding=0, rr pointer=0.
// - Reset mid-operation discards the output register and all tags.
// - Post-reset mem responses stall (mem_resp_ready=0).
// - Output register states:
//   - EMPTY (mem_req_valid=0): may load.
//   - FULL (mem_req_valid=1): loads only in the cycle mem_req_ready=1, giving back-to-back issue.
// - Load condition: (EMPTY or mem_req_ready) and |udev_req_valid and tag-space ok.
// - On load:
//   - Winner = first valid port at or after rr pointer, wrapping modulo N.
//   - udev_req_ready[winner]=1 combinationally in that cycle only.
//   - Fields are captured and mem_req_valid=1 next cycle.
//   - rr pointer <= (winner+1) mod N.
// - Request latency: udev accept to mem_req_valid = 1 cycle.
// - mem_req fields are stable while mem_req_valid && !mem_req_ready.
// - Tag push on load unless cmd[4:0]==UMI_REQ_POSTED (5'h05); tag = winner index.
// - Tag-space ok = (count < OUTSTANDING) or request is posted.
// - A pop in the same cycle does not free space (conservative).
// - Response routing, with head = FIFO head tag:
//   - If FIFO is non-empty: udev_resp_valid[head] = mem_resp_valid and mem_resp_ready = udev_resp_ready[head].
//   - If FIFO is empty: all udev_resp_valid=0 and mem_resp_ready=0.
// - Pop when mem_resp_valid && mem_resp_ready. Push and pop in the same cycle leave the count unchanged.
// - Other ports' udev_resp_ready are ignored.
// - udev_req_valid dropping without accept is legal; the winner is recomputed every cycle until load.
// STRUCTURE
// - Package umi_sched_pkg:
//   - Opcode constants UMI_REQ_POSTED=5'h05 and UMI_OPCODE_MSB=4.
//   - Function is_posted(cmd).
//   - Localparam TW = (N>1) ? $clog2(N) : 1.
// - Sub-module umi_sched_tagfifo: sync FIFO, WIDTH=TW, DEPTH=OUTSTANDING, ports push/pop/head/count/full/empty.
// - Top holds the rr pointer, priority-rotate winner logic, output register and response demux.
// TESTING
// - Single read, port 2, mem_req_ready=1, mem responds after 3 cycles:
//   - udev_req_ready[2] pulses once.
//   - mem_req_valid next cycle with port-2 fields.
//   - udev_resp_valid[2] only.
// - All 5 ports request reads continuously, ready=1, rr=0: grant order 0,1,2,3,4,0.
//   - One mem_req per cycle with no bubbles.
// - OUTSTANDING=4, 4 reads issued, no responses: 5th read is not accepted.
//   - After the 1st response pops, the 5th is accepted next cycle.
// - Posted writes (cmd[4:0]=5'h05) from port 1 while FIFO is full: accepted, outstanding stays 4, no response routed.
// - mem_req_ready=0 for 6 cycles with 3 ports pending: mem_req fields stable and udev_req_ready=0 throughout.
//   - The first load after ready rises goes to the rr winner.
// - Reset asserted with 2 tags outstanding and mem_req_valid=1:
//   - Next cycle all outputs at reset values, outstanding=0.
//   - A stray mem_resp_valid sees mem_resp_ready=0.

Source files
------------

// File: rtl/umi_sched_pkg.sv
// Shared constants, types and helpers for the UMI RAM request scheduler.
package umi_sched_pkg;

  // Opcode lives in the low bits of the UMI command word.
  localparam int unsigned UMI_OPCODE_MSB = 4;
  localparam logic [UMI_OPCODE_MSB:0] UMI_REQ_POSTED = 5'h05;

  // Output register occupancy toward the RAM.
  typedef enum logic {
    OregEmpty,
    OregFull
  } oreg_state_e;

  // Posted requests never produce a response, so they take no tag.
  function automatic logic is_posted(input logic [UMI_OPCODE_MSB:0] opcode);
    return opcode == UMI_REQ_POSTED;
  endfunction

  // Width of a port index; a single port still needs one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/umi_sched_tagfifo.sv
// Synchronous tag FIFO remembering which host port owns each in-flight response.
module umi_sched_tagfifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap freely.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; reset drops every tag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/umi_ram_sched.sv
// Round-robin scheduler sharing one UMI RAM port among N host ports, with in-order
// response return through a tag FIFO.
module umi_ram_sched
  import umi_sched_pkg::*;
#(
  parameter int unsigned N           = 5,
  parameter int unsigned CW          = 32,
  parameter int unsigned AW          = 64,
  parameter int unsigned DW          = 256,
  parameter int unsigned OUTSTANDING = 4,
  localparam int unsigned TW         = tag_width(N),
  localparam int unsigned OW         = $clog2(OUTSTANDING) + 1
) (
  input  logic            clk,
  input  logic            reset,
  // host request ports
  input  logic [N-1:0]    udev_req_valid,
  input  logic [N*CW-1:0] udev_req_cmd,
  input  logic [N*AW-1:0] udev_req_dstaddr,
  input  logic [N*AW-1:0] udev_req_srcaddr,
  input  logic [N*DW-1:0] udev_req_data,
  output logic [N-1:0]    udev_req_ready,
  // request toward RAM
  output logic            mem_req_valid,
  output logic [CW-1:0]   mem_req_cmd,
  output logic [AW-1:0]   mem_req_dstaddr,
  output logic [AW-1:0]   mem_req_srcaddr,
  output logic [DW-1:0]   mem_req_data,
  input  logic            mem_req_ready,
  // response from RAM
  input  logic            mem_resp_valid,
  input  logic [CW-1:0]   mem_resp_cmd,
  input  logic [AW-1:0]   mem_resp_dstaddr,
  input  logic [AW-1:0]   mem_resp_srcaddr,
  input  logic [DW-1:0]   mem_resp_data,
  output logic            mem_resp_ready,
  // host response ports
  output logic [N-1:0]    udev_resp_valid,
  output logic [N*CW-1:0] udev_resp_cmd,
  output logic [N*AW-1:0] udev_resp_dstaddr,
  output logic [N*AW-1:0] udev_resp_srcaddr,
  output logic [N*DW-1:0] udev_resp_data,
  input  logic [N-1:0]    udev_resp_ready,
  output logic [OW-1:0]   outstanding
);

  logic [CW-1:0] req_cmd [N];
  logic [AW-1:0] req_dst [N];
  logic [AW-1:0] req_src [N];
  logic [DW-1:0] req_data [N];

  oreg_state_e   state_q, state_d;
  logic [TW-1:0] rr_q, rr_d;
  logic [TW-1:0] winner, idx;
  logic          any_valid;
  logic          win_posted;
  logic          load;

  logic [CW-1:0] cmd_q, cmd_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] src_q, src_d;
  logic [DW-1:0] data_q, data_d;

  logic [TW-1:0] fifo_head;
  logic          fifo_full, fifo_empty;
  logic          tag_push, tag_pop;

  // Unpack the flat host buses and broadcast the RAM response to every port.
  for (genvar g = 0; g < N; g++) begin : g_port
    assign req_cmd[g]  = udev_req_cmd[g*CW +: CW];
    assign req_dst[g]  = udev_req_dstaddr[g*AW +: AW];
    assign req_src[g]  = udev_req_srcaddr[g*AW +: AW];
    assign req_data[g] = udev_req_data[g*DW +: DW];
    assign udev_resp_cmd[g*CW +: CW]     = mem_resp_cmd;
    assign udev_resp_dstaddr[g*AW +: AW] = mem_resp_dstaddr;
    assign udev_resp_srcaddr[g*AW +: AW] = mem_resp_srcaddr;
    assign udev_resp_data[g*DW +: DW]    = mem_resp_data;
  end

  // Priority rotate: first valid port at or after the rr pointer, wrapping modulo N.
  always_comb begin
    winner    = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = TW'((32'(rr_q) + i) % N);
      if (!any_valid && udev_req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  assign win_posted = is_posted(req_cmd[winner][UMI_OPCODE_MSB:0]);

  // A pop in the same cycle does not open tag space; keeps the full check off the
  // response path.
  assign load = !reset && any_valid && ((state_q == OregEmpty) || mem_req_ready) &&
                (!fifo_full || win_posted);

  // Grant is a combinational one-hot pulse in the load cycle only.
  always_comb begin
    udev_req_ready = '0;
    if (load) udev_req_ready[winner] = 1'b1;
  end

  // Output register and rr pointer next-state.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cmd_d   = cmd_q;
    dst_d   = dst_q;
    src_d   = src_q;
    data_d  = data_q;
    if (load) begin
      state_d = OregFull;
      rr_d    = (winner == TW'(N - 1)) ? '0 : winner + TW'(1);
      cmd_d   = req_cmd[winner];
      dst_d   = req_dst[winner];
      src_d   = req_src[winner];
      data_d  = req_data[winner];
    end else if (mem_req_ready) begin
      state_d = OregEmpty;
    end
  end

  // Control state; reset empties the output register and rewinds the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OregEmpty;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Request payload; only meaningful while the register is full.
  always_ff @(posedge clk) begin
    cmd_q  <= cmd_d;
    dst_q  <= dst_d;
    src_q  <= src_d;
    data_q <= data_d;
  end

  assign mem_req_valid   = (state_q == OregFull);
  assign mem_req_cmd     = cmd_q;
  assign mem_req_dstaddr = dst_q;
  assign mem_req_srcaddr = src_q;
  assign mem_req_data    = data_q;

  assign tag_push = load && !win_posted;
  assign tag_pop  = mem_resp_valid && mem_resp_ready;

  umi_sched_tagfifo #(
    .WIDTH(TW),
    .DEPTH(OUTSTANDING)
  ) u_tagfifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (tag_push),
    .push_data_i(winner),
    .pop_i      (tag_pop),
    .head_o     (fifo_head),
    .count_o    (outstanding),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Route the response to the port owning the oldest tag; stall when nothing is owed.
  always_comb begin
    udev_resp_valid = '0;
    mem_resp_ready  = 1'b0;
    if (!fifo_empty) begin
      udev_resp_valid[fifo_head] = mem_resp_valid;
      mem_resp_ready             = udev_resp_ready[fifo_head];
    end
  end

endmodule

// File: tb/tb_umi_ram_sched.sv
// Self-checking bench for umi_ram_sched: directed scenarios plus a randomized run,
// all compared against a queue-based reference model.
module tb_umi_ram_sched;

  localparam int N  = 5;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int OUTSTANDING = 4;
  localparam int OW = $clog2(OUTSTANDING) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    udev_req_valid;
  logic [N*CW-1:0] udev_req_cmd;
  logic [N*AW-1:0] udev_req_dstaddr, udev_req_srcaddr;
  logic [N*DW-1:0] udev_req_data;
  logic [N-1:0]    udev_req_ready;
  logic            mem_req_valid, mem_req_ready;
  logic [CW-1:0]   mem_req_cmd;
  logic [AW-1:0]   mem_req_dstaddr, mem_req_srcaddr;
  logic [DW-1:0]   mem_req_data;
  logic            mem_resp_valid, mem_resp_ready;
  logic [CW-1:0]   mem_resp_cmd;
  logic [AW-1:0]   mem_resp_dstaddr, mem_resp_srcaddr;
  logic [DW-1:0]   mem_resp_data;
  logic [N-1:0]    udev_resp_valid, udev_resp_ready;
  logic [N*CW-1:0] udev_resp_cmd;
  logic [N*AW-1:0] udev_resp_dstaddr, udev_resp_srcaddr;
  logic [N*DW-1:0] udev_resp_data;
  logic [OW-1:0]   outstanding;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            rr_m = 0;
  bit            mvalid_m = 0;
  logic [CW-1:0] mcmd_m;
  logic [AW-1:0] mdst_m, msrc_m;
  logic [DW-1:0] mdata_m;
  int            tagq[$];
  // Model results for the current cycle
  int            win_m;
  bit            load_m, pop_m, posted_m;
  logic [N-1:0]  exp_rdy, exp_rvalid;
  logic          exp_mrr;

  always #5 clk = ~clk;

  umi_ram_sched #(
    .N(N), .CW(CW), .AW(AW), .DW(DW), .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .udev_req_valid   (udev_req_valid),
    .udev_req_cmd     (udev_req_cmd),
    .udev_req_dstaddr (udev_req_dstaddr),
    .udev_req_srcaddr (udev_req_srcaddr),
    .udev_req_data    (udev_req_data),
    .udev_req_ready   (udev_req_ready),
    .mem_req_valid    (mem_req_valid),
    .mem_req_cmd      (mem_req_cmd),
    .mem_req_dstaddr  (mem_req_dstaddr),
    .mem_req_srcaddr  (mem_req_srcaddr),
    .mem_req_data     (mem_req_data),
    .mem_req_ready    (mem_req_ready),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_cmd     (mem_resp_cmd),
    .mem_resp_dstaddr (mem_resp_dstaddr),
    .mem_resp_srcaddr (mem_resp_srcaddr),
    .mem_resp_data    (mem_resp_data),
    .mem_resp_ready   (mem_resp_ready),
    .udev_resp_valid  (udev_resp_valid),
    .udev_resp_cmd    (udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr),
    .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data   (udev_resp_data),
    .udev_resp_ready  (udev_resp_ready),
    .outstanding      (outstanding)
  );

  // Expected combinational outputs from the current inputs and model state.
  task automatic model_comb();
    bit any = 0;
    win_m = 0;
    for (int i = 0; i < N; i++) begin
      int p = (rr_m + i) % N;
      if (!any && udev_req_valid[p]) begin
        any = 1;
        win_m = p;
      end
    end
    posted_m = (udev_req_cmd[win_m*CW +: 5] == 5'h05);
    load_m = !reset && any && (!mvalid_m || mem_req_ready) &&
             (tagq.size() < OUTSTANDING || posted_m);
    exp_rdy = '0;
    if (load_m) exp_rdy[win_m] = 1'b1;
    exp_rvalid = '0;
    exp_mrr = 1'b0;
    if (tagq.size() > 0) begin
      exp_rvalid[tagq[0]] = mem_resp_valid;
      exp_mrr = udev_resp_ready[tagq[0]];
    end
    pop_m = exp_mrr && mem_resp_valid;
  endtask

  // Advance the model across one clock edge.
  task automatic model_clock();
    if (reset) begin
      tagq.delete();
      mvalid_m = 0;
      rr_m = 0;
    end else begin
      if (pop_m) void'(tagq.pop_front());
      if (load_m) begin
        mvalid_m = 1;
        mcmd_m  = udev_req_cmd[win_m*CW +: CW];
        mdst_m  = udev_req_dstaddr[win_m*AW +: AW];
        msrc_m  = udev_req_srcaddr[win_m*AW +: AW];
        mdata_m = udev_req_data[win_m*DW +: DW];
        rr_m = (win_m + 1) % N;
        if (!posted_m) tagq.push_back(win_m);
      end else if (mem_req_ready) begin
        mvalid_m = 0;
      end
    end
  endtask

  task automatic cycle();
    model_comb();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input bit posted);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [4:0]    op;
    c  = $urandom;
    op = 5'($urandom_range(0, 31));
    if (posted) op = 5'h05;
    else if (op == 5'h05) op = 5'h01;
    c[4:0] = op;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    udev_req_valid[p] = 1'b1;
    udev_req_cmd[p*CW +: CW]     = c;
    udev_req_dstaddr[p*AW +: AW] = {$urandom, $urandom};
    udev_req_srcaddr[p*AW +: AW] = {$urandom, $urandom};
    udev_req_data[p*DW +: DW]    = d;
  endtask

  task automatic set_resp();
    mem_resp_cmd     = $urandom;
    mem_resp_dstaddr = {$urandom, $urandom};
    mem_resp_srcaddr = {$urandom, $urandom};
    for (int k = 0; k < DW / 32; k++) mem_resp_data[k*32 +: 32] = $urandom;
  endtask

  task automatic clear_inputs();
    reset = 1'b0;
    udev_req_valid = '0;
    udev_req_cmd = '0;
    udev_req_dstaddr = '0;
    udev_req_srcaddr = '0;
    udev_req_data = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_cmd = '0;
    mem_resp_dstaddr = '0;
    mem_resp_srcaddr = '0;
    mem_resp_data = '0;
    udev_resp_ready = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    udev_req_valid = N'($urandom);
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    udev_resp_ready = '1;
    cycle();
    cycle();
    checks++; if (udev_req_ready !== '0) begin errors++;
      $display("FAIL reset_req_ready: got %b exp 0", udev_req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL reset_mem_req_valid: got %b exp 0", mem_req_valid); end
    checks++; if (outstanding !== '0) begin errors++;
      $display("FAIL reset_outstanding: got %0d exp 0", outstanding); end
    checks++; if (udev_resp_valid !== '0) begin errors++;
      $display("FAIL reset_resp_valid: got %b exp 0", udev_resp_valid); end
    checks++; if (mem_resp_ready !== 1'b0) begin errors++;
      $display("FAIL reset_mem_resp_ready: got %b exp 0", mem_resp_ready); end
    clear_inputs();
  endtask

  task automatic test_single_read();
    mem_req_ready = 1'b1;
    set_req(2, 0);
    #1;
    checks++; if (udev_req_ready !== 5'b00100) begin errors++;
      $display("FAIL single_grant: got %b exp 00100", udev_req_ready); end
    cycle();
    udev_req_valid = '0;
    #1;
    checks++; if (udev_req_ready !== '0) begin errors++;
      $display("FAIL single_grant_once: got %b exp 0", udev_req_ready); end
    checks++; if (mem_req_valid !== 1'b1 || mem_req_cmd !== udev_req_cmd[2*CW +: CW]) begin
      errors++; $display("FAIL single_issue: got v=%b cmd=%h exp v=1 cmd=%h", mem_req_valid,
                         mem_req_cmd, udev_req_cmd[2*CW +: CW]); end
    checks++; if (mem_req_dstaddr !== udev_req_dstaddr[2*AW +: AW] ||
                  mem_req_srcaddr !== udev_req_srcaddr[2*AW +: AW] ||
                  mem_req_data !== udev_req_data[2*DW +: DW]) begin errors++;
      $display("FAIL single_fields: got dst=%h src=%h exp dst=%h src=%h", mem_req_dstaddr,
               mem_req_srcaddr, udev_req_dstaddr[2*AW +: AW], udev_req_srcaddr[2*AW +: AW]); end
    checks++; if (outstanding !== 1) begin errors++;
      $display("FAIL single_outstanding: got %0d exp 1", outstanding); end
    cycle();
    checks++; if (mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL single_drain: got %b exp 0", mem_req_valid); end
    cycle();
    cycle();
    set_resp();
    mem_resp_valid = 1'b1;
    udev_resp_ready = 5'b11011;
    #1;
    checks++; if (udev_resp_valid !== 5'b00100) begin errors++;
      $display("FAIL single_resp_route: got %b exp 00100", udev_resp_valid); end
    checks++; if (mem_resp_ready !== 1'b0) begin errors++;
      $display("FAIL single_other_ready_ignored: got %b exp 0", mem_resp_ready); end
    udev_resp_ready = 5'b00100;
    #1;
    checks++; if (mem_resp_ready !== 1'b1) begin errors++;
      $display("FAIL single_resp_ready: got %b exp 1", mem_resp_ready); end
    checks++; if (udev_resp_data[2*DW +: DW] !== mem_resp_data ||
                  udev_resp_cmd[4*CW +: CW] !== mem_resp_cmd) begin errors++;
      $display("FAIL single_resp_bcast: got cmd=%h exp %h", udev_resp_cmd[4*CW +: CW],
               mem_resp_cmd); end
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 0 || udev_resp_valid !== '0) begin errors++;
      $display("FAIL single_pop: got out=%0d rv=%b exp 0", outstanding, udev_resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] one_hot;
    do_reset();
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    udev_resp_ready = '1;
    set_resp();
    for (int p = 0; p < N; p++) set_req(p, 0);
    for (int k = 0; k < 6; k++) begin
      #1;
      model_comb();
      one_hot = '0;
      one_hot[k % N] = 1'b1;
      checks++; if (udev_req_ready !== one_hot) begin errors++;
        $display("FAIL b2b_grant_%0d: got %b exp %b", k, udev_req_ready, one_hot); end
      checks++; if (udev_resp_valid !== exp_rvalid) begin errors++;
        $display("FAIL b2b_resp_%0d: got %b exp %b", k, udev_resp_valid, exp_rvalid); end
      cycle();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_cmd !== mcmd_m) begin errors++;
        $display("FAIL b2b_issue_%0d: got v=%b cmd=%h exp v=1 cmd=%h", k, mem_req_valid,
                 mem_req_cmd, mcmd_m); end
      set_req(k % N, 0);
    end
    udev_req_valid = '0;
    for (int k = 0; k < 8 && tagq.size() > 0; k++) cycle();
    checks++; if (tagq.size() != 0 || outstanding !== 0) begin errors++;
      $display("FAIL b2b_drain: got %0d exp 0", outstanding); end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_outstanding();
    do_reset();
    mem_req_ready = 1'b1;
    for (int p = 0; p < N; p++) set_req(p, 0);
    for (int k = 0; k < OUTSTANDING; k++) begin
      #1;
      model_comb();
      checks++; if (udev_req_ready !== exp_rdy || $countones(udev_req_ready) != 1) begin
        errors++; $display("FAIL fill_grant_%0d: got %b exp %b", k, udev_req_ready, exp_rdy); end
      cycle();
    end
    checks++; if (outstanding !== OW'(OUTSTANDING)) begin errors++;
      $display("FAIL fill_count: got %0d exp %0d", outstanding, OUTSTANDING); end
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (udev_req_ready !== '0) begin errors++;
        $display("FAIL full_block_%0d: got %b exp 0", k, udev_req_ready); end
      cycle();
    end
    set_resp();
    mem_resp_valid = 1'b1;
    udev_resp_ready = '1;
    #1;
    checks++; if (udev_req_ready !== '0 || mem_resp_ready !== 1'b1) begin errors++;
      $display("FAIL pop_no_free: got rdy=%b mrr=%b exp rdy=0 mrr=1", udev_req_ready,
               mem_resp_ready); end
    cycle();
    mem_resp_valid = 1'b0;
    #1;
    model_comb();
    checks++; if (udev_req_ready !== exp_rdy || exp_rdy == '0 || outstanding !== 3) begin
      errors++; $display("FAIL after_pop: got rdy=%b out=%0d exp rdy=%b out=3", udev_req_ready,
                         outstanding, exp_rdy); end
    cycle();
    checks++; if (outstanding !== 4 || mem_req_valid !== 1'b1) begin errors++;
      $display("FAIL fifth_issue: got out=%0d v=%b exp 4 1", outstanding, mem_req_valid); end
    udev_req_valid = '0;
  endtask

  task automatic test_posted();
    for (int k = 0; k < 3; k++) begin
      udev_req_valid = '0;
      set_req(1, 1);
      #1;
      checks++; if (udev_req_ready !== 5'b00010) begin errors++;
        $display("FAIL posted_grant_%0d: got %b exp 00010", k, udev_req_ready); end
      cycle();
      checks++; if (outstanding !== 4 || mem_req_cmd !== udev_req_cmd[CW +: CW]) begin
        errors++; $display("FAIL posted_issue_%0d: got out=%0d cmd=%h exp 4 %h", k,
                           outstanding, mem_req_cmd, udev_req_cmd[CW +: CW]); end
      checks++; if (udev_resp_valid !== '0) begin errors++;
        $display("FAIL posted_no_resp_%0d: got %b exp 0", k, udev_resp_valid); end
    end
    udev_req_valid = '0;
    mem_resp_valid = 1'b1;
    udev_resp_ready = '1;
    for (int k = 0; k < OUTSTANDING; k++) begin
      set_resp();
      #1;
      model_comb();
      checks++; if (udev_resp_valid !== exp_rvalid) begin errors++;
        $display("FAIL drain_route_%0d: got %b exp %b", k, udev_resp_valid, exp_rvalid); end
      cycle();
    end
    checks++; if (outstanding !== 0) begin errors++;
      $display("FAIL drain_count: got %0d exp 0", outstanding); end
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_stall();
    int a, b;
    do_reset();
    mem_req_ready = 1'b1;
    set_req(0, 0);
    cycle();
    udev_req_valid = '0;
    mem_req_ready = 1'b0;
    a = $urandom_range(0, N - 1);
    b = (a + $urandom_range(1, N - 1)) % N;
    for (int p = 0; p < N; p++) if (p != a && p != b) set_req(p, 0);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (udev_req_ready !== '0) begin errors++;
        $display("FAIL stall_grant_%0d: got %b exp 0", k, udev_req_ready); end
      checks++; if (mem_req_valid !== 1'b1 || mem_req_cmd !== mcmd_m ||
                    mem_req_data !== mdata_m || mem_req_dstaddr !== mdst_m) begin errors++;
        $display("FAIL stall_hold_%0d: got v=%b cmd=%h exp v=1 cmd=%h", k, mem_req_valid,
                 mem_req_cmd, mcmd_m); end
      cycle();
    end
    mem_req_ready = 1'b1;
    #1;
    model_comb();
    checks++; if (udev_req_ready !== exp_rdy) begin errors++;
      $display("FAIL stall_release: got %b exp %b", udev_req_ready, exp_rdy); end
    cycle();
    checks++; if (mem_req_cmd !== mcmd_m) begin errors++;
      $display("FAIL stall_reload: got %h exp %h", mem_req_cmd, mcmd_m); end
    udev_req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_req_ready = 1'b1;
    set_req(3, 0);
    set_req(4, 0);
    cycle();
    cycle();
    mem_req_ready = 1'b0;
    udev_req_valid = '0;
    set_req(0, 0);
    #1;
    checks++; if (outstanding !== 2 || mem_req_valid !== 1'b1) begin errors++;
      $display("FAIL mid_setup: got out=%0d v=%b exp 2 1", outstanding, mem_req_valid); end
    reset = 1'b1;
    cycle();
    checks++; if (mem_req_valid !== 1'b0 || outstanding !== 0 || udev_req_ready !== '0) begin
      errors++; $display("FAIL mid_reset: got v=%b out=%0d rdy=%b exp 0 0 0", mem_req_valid,
                         outstanding, udev_req_ready); end
    reset = 1'b0;
    udev_req_valid = '0;
    mem_resp_valid = 1'b1;
    udev_resp_ready = '1;
    #1;
    checks++; if (mem_resp_ready !== 1'b0 || udev_resp_valid !== '0) begin errors++;
      $display("FAIL mid_stray_resp: got mrr=%b rv=%b exp 0 0", mem_resp_ready,
               udev_resp_valid); end
    cycle();
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      udev_req_valid = N'($urandom);
      for (int p = 0; p < N; p++) if (udev_req_valid[p]) set_req(p, $urandom_range(0, 2) == 0);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_resp_valid = $urandom_range(0, 1) == 1;
      udev_resp_ready = N'($urandom);
      set_resp();
      #1;
      model_comb();
      checks++; if (udev_req_ready !== exp_rdy) begin errors++;
        $display("FAIL rnd_grant_%0d: got %b exp %b", k, udev_req_ready, exp_rdy); end
      checks++; if (udev_resp_valid !== exp_rvalid || mem_resp_ready !== exp_mrr) begin
        errors++; $display("FAIL rnd_resp_%0d: got rv=%b mrr=%b exp rv=%b mrr=%b", k,
                           udev_resp_valid, mem_resp_ready, exp_rvalid, exp_mrr); end
      cycle();
      checks++; if (mem_req_valid !== mvalid_m || outstanding !== tagq.size()) begin errors++;
        $display("FAIL rnd_state_%0d: got v=%b out=%0d exp v=%b out=%0d", k, mem_req_valid,
                 outstanding, mvalid_m, tagq.size()); end
      if (mvalid_m) begin
        checks++; if (mem_req_cmd !== mcmd_m || mem_req_dstaddr !== mdst_m ||
                      mem_req_srcaddr !== msrc_m || mem_req_data !== mdata_m) begin errors++;
          $display("FAIL rnd_fields_%0d: got cmd=%h exp %h", k, mem_req_cmd, mcmd_m); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_outstanding();
    test_posted();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
